kb_div3_result_collector: RTL and testbench

KB_DIV3_RESULT_COLLECTOR -- requirements
Module: kb_div3_result_collector

---
 rtl/kb_div3_result_collector.sv | 164 ++++++++++++++++
 tb/tb_kb_div3_result_collector.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/kb_div3_result_collector.sv
// kb_div3_result_collector
// Tracks one in-flight launch of the divide-by-3 stage. It captures the
// quotient/remainder LATENCY cycles after the launch and checks that
// 3*q + r reproduces the dividend with r <= 2. Each checked result is buffered
// in a small FIFO for a ready/valid consumer.
//
// Ports:
//   sys_clock    in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   shift_en     in   launch strobe (shared with the divider stage)
//   divident     in   dividend presented with shift_en
//   quotient     in   divider quotient output
//   reminder     in   divider remainder output
//   out_valid    out  FIFO head holds a result
//   out_ready    in   consumer accepts the head
//   out_quotient out  head quotient
//   out_reminder out  head remainder
//   out_error    out  head check-failure flag
//   err_count    out  saturating count of failed checks
//   overflow     out  sticky: result dropped because the FIFO was full
//   collision    out  sticky: shift_en seen while a launch was in flight
module kb_div3_result_collector #(
  parameter int SIZE       = 20,
  parameter int LATENCY    = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            sys_clock,
  input  logic            reset_n,
  input  logic            shift_en,
  input  logic [SIZE-1:0] divident,
  input  logic [SIZE-1:0] quotient,
  input  logic [1:0]      reminder,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_quotient,
  output logic [1:0]      out_reminder,
  output logic            out_error,
  output logic [7:0]      err_count,
  output logic            overflow,
  output logic            collision
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 4;
  localparam int EW = SIZE + 3;
  localparam logic [AW:0] OCC_ONE  = (AW+1)'(1);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t          state;
  state_t          next_state;
  logic            launch;
  logic            capture;
  logic [CW-1:0]   cnt;
  logic [SIZE-1:0] exp_reg;

  logic [SIZE+1:0] recon;
  logic            chk_err;

  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     occ;
  logic            full;
  logic            pop;
  logic            push_ok;
  logic [EW-1:0]   head;

  // Launch / capture control
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    launch     = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (shift_en) begin
          launch     = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        // A shift_en arriving here (even on the capture edge) never starts a
        // new launch; it only raises collision.
        if (cnt == '0) begin
          capture    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      exp_reg <= '0;
    end else if (launch) begin
      cnt     <= CW'(LATENCY - 1);
      exp_reg <= divident;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Result check: 3*q + r at SIZE+2 bits against the zero-extended dividend
  assign recon   = {2'b00, quotient} + {1'b0, quotient, 1'b0} + {{SIZE{1'b0}}, reminder};
  assign chk_err = (reminder == 2'd3) || (recon != {2'b00, exp_reg});

  // Result FIFO
  assign full      = (occ == OCC_FULL);
  assign out_valid = (occ != '0);
  assign pop       = out_valid & out_ready;
  // When full, a simultaneous pop frees the slot being written.
  assign push_ok   = capture & (~full | pop);

  always_ff @(posedge sys_clock) begin
    if (push_ok) mem[wr_ptr] <= {quotient, reminder, chk_err};
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  assign head         = mem[rd_ptr];
  assign out_quotient = head[EW-1:3];
  assign out_reminder = head[2:1];
  assign out_error    = head[0];

  // Status flags
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
      overflow  <= 1'b0;
      collision <= 1'b0;
    end else begin
      if (capture && chk_err)        err_count <= sat_inc(err_count);
      if (capture && full && !pop)   overflow  <= 1'b1;
      if (state == WAIT && shift_en) collision <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kb_div3_result_collector.sv
module tb_kb_div3_result_collector;

  localparam int SIZE       = 20;
  localparam int LATENCY    = 6;
  localparam int FIFO_DEPTH = 4;

  logic            sys_clock = 1'b0;
  logic            reset_n   = 1'b0;
  logic            shift_en  = 1'b0;
  logic [SIZE-1:0] divident  = '0;
  logic [SIZE-1:0] quotient  = '0;
  logic [1:0]      reminder  = '0;
  logic            out_ready = 1'b1;
  logic            out_valid;
  logic [SIZE-1:0] out_quotient;
  logic [1:0]      out_reminder;
  logic            out_error;
  logic [7:0]      err_count;
  logic            overflow;
  logic            collision;

  int n_checks = 0;
  int n_fails  = 0;

  kb_div3_result_collector #(
    .SIZE(SIZE), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .sys_clock(sys_clock), .reset_n(reset_n), .shift_en(shift_en),
    .divident(divident), .quotient(quotient), .reminder(reminder),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_reminder(out_reminder),
    .out_error(out_error), .err_count(err_count),
    .overflow(overflow), .collision(collision)
  );

  always #5 sys_clock = ~sys_clock;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a launch is remembered with its edge number and
  // resolved LATENCY edges later; the FIFO is a plain queue.
  int     cyc = 0;
  bit     busy = 0;
  int     lcyc = 0;
  longint mexp = 0;
  int     mq_q[$];
  int     mq_r[$];
  int     mq_e[$];
  int     m_errs = 0;
  bit     m_ovf = 0;
  bit     m_col = 0;

  always @(negedge reset_n) begin
    busy = 0; m_errs = 0; m_ovf = 0; m_col = 0;
    mq_q.delete(); mq_r.delete(); mq_e.delete();
  end

  always @(posedge sys_clock) begin
    if (reset_n) begin
      bit     e;
      longint rec;
      cyc++;
      if (mq_q.size() > 0 && out_ready) begin
        void'(mq_q.pop_front()); void'(mq_r.pop_front()); void'(mq_e.pop_front());
      end
      if (busy && cyc == lcyc + LATENCY) begin
        rec = (3 * longint'(quotient) + longint'(reminder)) & ((longint'(1) << (SIZE + 2)) - 1);
        e   = (reminder > 2) || (rec != mexp);
        if (e && m_errs < 255) m_errs++;
        if (mq_q.size() < FIFO_DEPTH) begin
          mq_q.push_back(int'(quotient)); mq_r.push_back(int'(reminder)); mq_e.push_back(int'(e));
        end else begin
          m_ovf = 1;
        end
        if (shift_en) m_col = 1;
        busy = 0;
      end else if (busy) begin
        if (shift_en) m_col = 1;
      end else if (shift_en) begin
        busy = 1; lcyc = cyc; mexp = longint'(divident);
      end
    end
  end

  // Per-cycle compare against the model
  always @(posedge sys_clock) begin
    #2;
    if (reset_n) begin
      check("out_valid", out_valid, mq_q.size() != 0);
      if (mq_q.size() != 0) begin
        check("out_quotient", out_quotient, mq_q[0]);
        check("out_reminder", out_reminder, mq_r[0]);
        check("out_error", out_error, mq_e[0]);
      end
      check("err_count", err_count, m_errs);
      check("overflow", overflow, m_ovf);
      check("collision", collision, m_col);
    end
  end

  task automatic launch(input logic [SIZE-1:0] d, input logic [SIZE-1:0] q, input logic [1:0] r);
    @(negedge sys_clock);
    shift_en = 1'b1; divident = d; quotient = q; reminder = r;
    @(negedge sys_clock);
    shift_en = 1'b0;
  endtask

  task automatic run(input logic [SIZE-1:0] d, input logic [SIZE-1:0] q, input logic [1:0] r);
    launch(d, q, r);
    repeat (LATENCY) @(negedge sys_clock);
  endtask

  initial begin
    repeat (3) @(negedge sys_clock);
    reset_n = 1'b1;
    @(posedge sys_clock); #2;
    check("lit_reset_valid", out_valid, 0);
    check("lit_reset_errcnt", err_count, 0);
    check("lit_reset_ovf", overflow, 0);
    check("lit_reset_col", collision, 0);

    // 9 / 3: result visible in the cycle after the sixth edge
    out_ready = 1'b0;
    launch(20'd9, 20'd3, 2'd0);
    repeat (5) @(posedge sys_clock); #2;
    check("lit_first_early", out_valid, 0);
    @(posedge sys_clock); #2;
    check("lit_first_valid", out_valid, 1);
    check("lit_first_q", out_quotient, 3);
    check("lit_first_r", out_reminder, 0);
    check("lit_first_err", out_error, 0);
    @(negedge sys_clock); out_ready = 1'b1;
    repeat (2) @(negedge sys_clock);

    // Boundary dividend, valid remainder, wrong quotient
    run(20'hFFFFF, 20'd349525, 2'd0);
    run(20'd10, 20'd3, 2'd1);
    run(20'd10, 20'd4, 2'd0);
    @(posedge sys_clock); #2;
    check("lit_errcnt_1", err_count, 1);

    // Illegal remainder with an otherwise consistent sum
    out_ready = 1'b0;
    run(20'd9, 20'd2, 2'd3);
    @(posedge sys_clock); #2;
    check("lit_r3_err", out_error, 1);
    check("lit_r3_rem", out_reminder, 3);
    check("lit_errcnt_2", err_count, 2);
    @(negedge sys_clock); out_ready = 1'b1;
    repeat (2) @(negedge sys_clock);

    // Five results into a four-entry buffer, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) run(20'(3 * (100 + i)), 20'(100 + i), 2'd0);
    @(posedge sys_clock); #2;
    check("lit_ovf", overflow, 1);
    check("lit_full_valid", out_valid, 1);
    @(negedge sys_clock); out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("lit_drain_order", out_quotient, 100 + i);
      @(negedge sys_clock);
    end
    check("lit_drained", out_valid, 0);

    // shift_en during cycle 3 of WAIT
    launch(20'd30, 20'd10, 2'd0);
    repeat (2) @(negedge sys_clock);
    shift_en = 1'b1; divident = 20'd999;
    @(negedge sys_clock); shift_en = 1'b0;
    repeat (8) @(negedge sys_clock);
    check("lit_col", collision, 1);

    // shift_en on the capture edge itself: no new launch
    launch(20'd33, 20'd11, 2'd0);
    repeat (5) @(negedge sys_clock);
    shift_en = 1'b1; divident = 20'd5;
    @(negedge sys_clock); shift_en = 1'b0;
    repeat (10) @(negedge sys_clock);

    // Reset during cycle 2 of WAIT
    launch(20'd9, 20'd3, 2'd0);
    @(negedge sys_clock);
    reset_n = 1'b0;
    repeat (2) @(negedge sys_clock);
    reset_n = 1'b1;
    repeat (10) @(negedge sys_clock);
    check("lit_rst_valid", out_valid, 0);
    check("lit_rst_ovf", overflow, 0);
    check("lit_rst_col", collision, 0);
    check("lit_rst_errcnt", err_count, 0);

    // 300 failing checks saturate the counter
    for (int i = 0; i < 300; i++) run(20'd1, 20'd1, 2'd0);
    @(posedge sys_clock); #2;
    check("lit_errcnt_sat", err_count, 255);

    repeat (3) @(negedge sys_clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
